mode_counter: RTL and testbench
===============================

Name: mode_counter

Overview:
Parametrised, runtime-configurable counter with a runtime limit, up/down direction, and three counting modes: wrap, saturate and one-shot. It also supports synchronous load/clear and terminal-count signalling. It is the general-purpose replacement for the fixed "count to N and stop" counters used in sequencing and timeout logic across the design. Instantiators select the mode per use instead of writing a bespoke counter.

Parameters:
WIDTH, 5, bit width of count, limit and load_val (legal 2..32)
RST_VAL, 0, count value after reset (must fit in WIDTH bits)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count-step enable
mode  input  2  00 WRAP, 01 SATURATE, 10 ONESHOT, 11 reserved (behaves as WRAP)
dir  input  1  1 = up, 0 = down
limit  input  WIDTH  runtime upper bound of the count range 0..limit
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value written by load
clear  input  1  synchronous clear to 0
start  input  1  ONESHOT trigger pulse
count  output  WIDTH  current count (registered)
tc  output  1  registered one-cycle terminal-count pulse
done  output  1  sticky flag: terminal reached in SATURATE/ONESHOT
busy  output  1  ONESHOT run in progress

Behaviour:
- Reset: reset is synchronous and active-high on rst, single clock clk.
  - Reset values: count=RST_VAL, tc=0, done=0, busy=0, FSM=IDLE.
  - rst overrides everything, including mid-run.
- Priority per edge: rst > clear > load > start > count step.
- Terminal value T: limit when dir=1; 0 when dir=0.
- "At terminal":
  - up: count >= limit (covers a count above limit after a runtime limit change or a load);
  - down: count == 0.
- Step when not at terminal: up is count+1, down is count-1. Arithmetic is WIDTH bits; no carry out.
- clear: count<=0, done<=0, FSM<=IDLE, tc<=0.
- load: count<=load_val (any value, even > limit), done<=0, FSM<=IDLE, tc<=0.
- tc:
  - Set for exactly one cycle, on the edge where a count step (or wrap) lands count on T, or in WRAP performs the wrap.
  - Never set by load, clear or reset.
  - A count already held at T does not retrigger tc.
- WRAP mode, en=1:
  - At terminal: count <= 0 (up) or limit (down), and tc=1 on that edge.
  - Not at terminal: step normally; if the step lands on T, tc=1 on that edge.
  - Up with limit=0: count stays 0 and tc pulses every enabled cycle.
  - done is never set in WRAP mode.
- SATURATE mode, en=1:
  - Step until T is reached; on the landing edge count=T, tc=1, done=1.
  - At terminal, count holds. An up count above limit is clamped to limit on the next enabled edge, with no tc.
  - Holds until clear/load/rst, or a dir change that moves the terminal.
- ONESHOT mode, FSM states IDLE and RUN:
  - IDLE + start: count <= 0 (up) or limit (down), done<=0, busy<=1, go to RUN. count is held otherwise.
  - RUN + en: step. On reaching T: tc=1, done=1, busy<=0, go to IDLE; count holds T.
  - start while in RUN is ignored. en=0 freezes the run.
- en=0: count holds in every mode and tc=0.
- mode is sampled every cycle. If mode != ONESHOT, the FSM is forced to IDLE and busy=0. done holds until cleared.
- dir and limit may change at any cycle; the next step uses the new values.
- Latency: all outputs change only on the rising edge following the causing input; there are no combinational paths from input to output.

Test Plan:
1. WIDTH=5, SATURATE, up, limit=5, en=1 after reset → count 0,1,2,3,4,5,5,5…; tc high only in the cycle count first equals 5; done=1 from then on.
2. WRAP, down, limit=3, en=1, starting from clear → count 0→3 (wrap, tc),2,1,0(tc),3,2…; tc period 4 cycles; done stays 0.
3. ONESHOT, up, limit=4: start pulse → busy=1, count 0..4, tc and done at 4, busy=0. A second start mid-run is ignored; a start after done restarts from 0 and clears done.
4. Priority and load: load=1 with load_val=20 and limit=7, then en in SATURATE → count 20, then 7 with no tc. Same cycle clear=1 and load=1 → count=0.
5. rst asserted mid ONESHOT run at count=2 → next edge count=RST_VAL, busy=0, done=0, tc=0. With RST_VAL=9 and WIDTH=5, count=9 after reset.
6. Gaps and edge cases: en toggled 1,0,1 in WRAP with limit=0 up → count stays 0; tc pulses only on enabled edges. Runtime limit lowered below count in WRAP up → next enabled edge wraps to 0 with tc.

Source files
------------

// File: rtl/mode_counter.sv
// General-purpose counter: runtime limit, up/down, WRAP / SATURATE / ONESHOT modes,
// synchronous clear/load, registered terminal-count pulse and sticky done.
module mode_counter #(
  parameter int          WIDTH   = 5,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             clear_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             done_o,
  output logic             busy_o
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [1:0] M_SAT = 2'b01;
  localparam logic [1:0] M_ONE = 2'b10;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] term_val, step_val, restart_val;
  logic             at_term, lands;

  always_comb begin
    term_val    = dir_i ? limit_i : '0;
    restart_val = dir_i ? '0 : limit_i;
    // Up direction treats anything above limit as terminal (runtime limit drop or load).
    at_term     = dir_i ? (count_q >= limit_i) : (count_q == '0);
    step_val    = dir_i ? (count_q + 1'b1) : (count_q - 1'b1);
    lands       = (step_val == term_val);
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    state_d = state_q;
    if (clear_i) begin
      count_d = '0;
      done_d  = 1'b0;
      state_d = IDLE;
    end else if (load_i) begin
      count_d = load_val_i;
      done_d  = 1'b0;
      state_d = IDLE;
    end else if (mode_i == M_ONE) begin
      if (state_q == IDLE) begin
        if (start_i) begin
          count_d = restart_val;
          done_d  = 1'b0;
          state_d = RUN;
        end
      end else if (en_i) begin
        // A run that begins already at terminal (e.g. limit=0) finishes immediately.
        if (at_term || lands) begin
          count_d = term_val;
          tc_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = step_val;
        end
      end
    end else begin
      state_d = IDLE;
      if (en_i) begin
        if (mode_i == M_SAT) begin
          if (at_term) begin
            if (dir_i && (count_q > limit_i)) count_d = limit_i;
          end else begin
            count_d = step_val;
            if (lands) begin
              tc_d   = 1'b1;
              done_d = 1'b1;
            end
          end
        end else if (at_term) begin
          count_d = restart_val;
          tc_d    = 1'b1;
        end else begin
          count_d = step_val;
          tc_d    = lands;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= WIDTH'(RST_VAL);
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= IDLE;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q == RUN);

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter: driver pushes expected outputs, monitor pops and compares.
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, load = 1'b0, clear = 1'b0, start = 1'b0, dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [4:0] limit = '0, load_val = '0;
  logic [4:0] count, count9;
  logic       tc, done, busy, tc9, done9, busy9;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(5), .RST_VAL(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .dir_i(dir), .limit_i(limit),
    .load_i(load), .load_val_i(load_val), .clear_i(clear), .start_i(start),
    .count_o(count), .tc_o(tc), .done_o(done), .busy_o(busy));

  mode_counter #(.WIDTH(5), .RST_VAL(9)) u_dut9 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .dir_i(dir), .limit_i(limit),
    .load_i(load), .load_val_i(load_val), .clear_i(clear), .start_i(start),
    .count_o(count9), .tc_o(tc9), .done_o(done9), .busy_o(busy9));

  typedef struct {
    logic [4:0] c;
    logic       tc, done, busy, chk9;
    int         id;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0, ncyc = 0;

  // stimulus shadows; pulse inputs self-clear after one cycle
  logic       s_rst = 0, s_en = 0, s_load = 0, s_clear = 0, s_start = 0, s_dir = 0;
  logic [1:0] s_mode = 0;
  logic [4:0] s_limit = 0, s_ldv = 0;

  task automatic cmp(input string name, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, id, act, req);
    end
  endtask

  task automatic cyc(input logic [4:0] c, input logic t, input logic d, input logic b);
    exp_t e;
    @(negedge clk);
    rst = s_rst; en = s_en; load = s_load; clear = s_clear; start = s_start;
    dir = s_dir; mode = s_mode; limit = s_limit; load_val = s_ldv;
    e.c = c; e.tc = t; e.done = d; e.busy = b; e.chk9 = s_rst; e.id = ncyc;
    q.push_back(e);
    ncyc++;
    s_rst = 0; s_load = 0; s_clear = 0; s_start = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("count", e.id, int'(count), int'(e.c));
        cmp("tc",    e.id, int'(tc),    int'(e.tc));
        cmp("done",  e.id, int'(done),  int'(e.done));
        cmp("busy",  e.id, int'(busy),  int'(e.busy));
        if (e.chk9) begin
          cmp("count_rst9", e.id, int'(count9), 9);
          cmp("flags_rst9", e.id, int'({tc9, done9, busy9}), 0);
        end
      end
    end
  end

  initial begin
    int w;
    // reset, SATURATE up limit 5
    s_mode = 2'b01; s_dir = 1; s_limit = 5;
    s_rst = 1; cyc(0, 0, 0, 0);
    s_rst = 1; cyc(0, 0, 0, 0);
    s_en = 1;
    cyc(1, 0, 0, 0); cyc(2, 0, 0, 0); cyc(3, 0, 0, 0); cyc(4, 0, 0, 0);
    cyc(5, 1, 1, 0); cyc(5, 0, 1, 0); cyc(5, 0, 1, 0);
    // WRAP down limit 3 from clear
    s_mode = 2'b00; s_dir = 0; s_limit = 3;
    s_clear = 1; cyc(0, 0, 0, 0);
    cyc(3, 1, 0, 0); cyc(2, 0, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    cyc(3, 1, 0, 0); cyc(2, 0, 0, 0);
    // ONESHOT up limit 4
    s_mode = 2'b10; s_dir = 1; s_limit = 4;
    cyc(2, 0, 0, 0);
    s_start = 1; cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    s_start = 1; cyc(2, 0, 0, 1);
    cyc(3, 0, 0, 1);
    cyc(4, 1, 1, 0);
    cyc(4, 0, 1, 0);
    s_start = 1; cyc(0, 0, 0, 1);
    s_en = 0; cyc(0, 0, 0, 1);
    s_en = 1; cyc(1, 0, 0, 1); cyc(2, 0, 0, 1);
    // reset mid-run
    s_rst = 1; cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    // load above limit then SATURATE clamp; clear beats load
    s_mode = 2'b01; s_dir = 1; s_limit = 7; s_ldv = 20;
    s_load = 1; cyc(20, 0, 0, 0);
    cyc(7, 0, 0, 0); cyc(7, 0, 0, 0);
    s_clear = 1; s_load = 1; cyc(0, 0, 0, 0);
    // SATURATE down from 2
    s_dir = 0; s_ldv = 2; s_load = 1; cyc(2, 0, 0, 0);
    cyc(1, 0, 0, 0); cyc(0, 1, 1, 0); cyc(0, 0, 1, 0);
    // WRAP up limit 0 with en gaps; done is sticky across mode change
    s_mode = 2'b00; s_dir = 1; s_limit = 0;
    cyc(0, 1, 1, 0);
    s_en = 0; cyc(0, 0, 1, 0);
    s_en = 1; cyc(0, 1, 1, 0);
    s_clear = 1; cyc(0, 0, 0, 0);
    // runtime limit drop below count
    s_limit = 6;
    cyc(1, 0, 0, 0); cyc(2, 0, 0, 0); cyc(3, 0, 0, 0); cyc(4, 0, 0, 0);
    s_limit = 2;
    cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(2, 1, 0, 0); cyc(0, 1, 0, 0);
    // reserved mode behaves as WRAP
    s_mode = 2'b11;
    cyc(1, 0, 0, 0); cyc(2, 1, 0, 0); cyc(0, 1, 0, 0);
    s_en = 0; cyc(0, 0, 0, 0);

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
